// File: rtl/complex_if_array.sv
// complex_if_array: walks DEPTH elements of an external synchronous-read
// array, accumulating a mode-dependent function of each element, and pulses
// w_enable with the final sum in result.
// Optional feature: define COMPLEX_IF_WRITEBACK_EN to add a WB state after
// every EXEC that writes the low WIDTH bits of the running sum back to the
// element just read.
module complex_if_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int RES_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_enable,
  input  logic              init_i,
  output logic              controlArrWEnable_a,
  output logic [ADDR_W-1:0] controlArrAddr_a,
  input  logic [WIDTH-1:0]  controlArrRData_a,
  output logic [WIDTH-1:0]  controlArrWData_a,
  output logic              w_enable,
  output logic [RES_W-1:0]  result
);

  // Operand is built wide enough for 2*x and for the accumulator width.
  localparam int OP_W = ((WIDTH + 1) > RES_W) ? (WIDTH + 1) : RES_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef COMPLEX_IF_WRITEBACK_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DONE  = 3'd3,
    S_WB    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DONE  = 3'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic               init_q, init_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]  i_q, i_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               done_q, done_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [OP_W-1:0]    op_s;
  logic [RES_W-1:0]   acc_sum_s;
  logic               last_s;

  assign last_s = (i_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; r_enable only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (r_enable) state_d = S_FETCH;
        else          state_d = S_IDLE;
      end
      S_FETCH: state_d = S_EXEC;
`ifdef COMPLEX_IF_WRITEBACK_EN
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        if (last_s) state_d = S_DONE;
        else        state_d = S_FETCH;
      end
`else
      S_EXEC: begin
        if (last_s) state_d = S_DONE;
        else        state_d = S_FETCH;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand selection: zero elements map to a mode constant, others to x or 2x.
  always_comb begin
    if (controlArrRData_a == {WIDTH{1'b0}}) begin
      if (init_q) op_s = OP_W'(2);
      else        op_s = OP_W'(3);
    end else begin
      if (init_q) op_s = OP_W'(controlArrRData_a);
      else        op_s = OP_W'({controlArrRData_a, 1'b0});
    end
    acc_sum_s = acc_q + op_s[RES_W-1:0];
  end

  // Datapath next values; index advances only when leaving for another FETCH.
  always_comb begin
    init_d = init_q;
    acc_d  = acc_q;
    i_d    = i_q;
    case (state_q)
      S_IDLE: begin
        if (r_enable) begin
          init_d = init_i;
          acc_d  = {RES_W{1'b0}};
          i_d    = {ADDR_W{1'b0}};
        end else begin
          init_d = init_q;
        end
      end
      S_EXEC: begin
        acc_d = acc_sum_s;
`ifndef COMPLEX_IF_WRITEBACK_EN
        if (!last_s) i_d = i_q + ADDR_W'(1);
        else         i_d = i_q;
`endif
      end
`ifdef COMPLEX_IF_WRITEBACK_EN
      S_WB: begin
        if (!last_s) i_d = i_q + ADDR_W'(1);
        else         i_d = i_q;
      end
`endif
      default: begin
        i_d = i_q;
      end
    endcase
  end

  // Output next values: address tracks i in FETCH/WB, result loads on entering DONE.
  always_comb begin
`ifdef COMPLEX_IF_WRITEBACK_EN
    if ((state_d == S_FETCH) || (state_d == S_WB)) addr_d = i_d;
    else                                            addr_d = addr_q;
`else
    if (state_d == S_FETCH) addr_d = i_d;
    else                    addr_d = addr_q;
`endif
    done_d = (state_d == S_DONE);
    if (done_d) result_d = acc_d;
    else        result_d = result_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_q   <= 1'b0;
      acc_q    <= {RES_W{1'b0}};
      i_q      <= {ADDR_W{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      done_q   <= 1'b0;
      result_q <= {RES_W{1'b0}};
    end else begin
      init_q   <= init_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

`ifdef COMPLEX_IF_WRITEBACK_EN
  logic             wen_q, wen_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [OP_W-1:0]  acc_ext_s;

  // Write strobe is high only for the WB cycle; data is the updated sum.
  always_comb begin
    acc_ext_s = OP_W'(acc_d);
    wen_d     = (state_d == S_WB);
    if (wen_d) wdata_d = acc_ext_s[WIDTH-1:0];
    else       wdata_d = wdata_q;
  end

  // Writeback port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      wdata_q <= {WIDTH{1'b0}};
    end else begin
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  assign controlArrWEnable_a = wen_q;
  assign controlArrWData_a   = wdata_q;
`else
  assign controlArrWEnable_a = 1'b0;
  assign controlArrWData_a   = {WIDTH{1'b0}};
`endif

  assign controlArrAddr_a = addr_q;
  assign w_enable         = done_q;
  assign result           = result_q;

endmodule

// File: tb/tb_complex_if_array.sv
// Self-checking bench for complex_if_array: directed cases plus random
// arrays, checked against a sum-of-operands reference model.
module tb_complex_if_array;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int RES_W   = 16;
  localparam int RES_W_S = 4;
`ifdef COMPLEX_IF_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam int LAT = WB ? 3 * DEPTH : 2 * DEPTH;

  logic clk;
  logic rst;
  logic r_enable0, r_enable1;
  logic init_i;

  logic                wen0, wen1;
  logic [ADDR_W-1:0]   addr0, addr1;
  logic [WIDTH-1:0]    rdata0, rdata1;
  logic [WIDTH-1:0]    wdata0, wdata1;
  logic                w_enable0, w_enable1;
  logic [RES_W-1:0]    result0;
  logic [RES_W_S-1:0]  result1;

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint last_res = 0;

  complex_if_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RES_W(RES_W)) u_dut (
    .clk(clk), .rst(rst), .r_enable(r_enable0), .init_i(init_i),
    .controlArrWEnable_a(wen0), .controlArrAddr_a(addr0),
    .controlArrRData_a(rdata0), .controlArrWData_a(wdata0),
    .w_enable(w_enable0), .result(result0)
  );

  complex_if_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RES_W(RES_W_S)) u_dut_s (
    .clk(clk), .rst(rst), .r_enable(r_enable1), .init_i(init_i),
    .controlArrWEnable_a(wen1), .controlArrAddr_a(addr1),
    .controlArrRData_a(rdata1), .controlArrWData_a(wdata1),
    .w_enable(w_enable1), .result(result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle synchronous-read array model per DUT.
  always @(posedge clk) begin
    rdata0 <= mem[addr0];
    rdata1 <= mem[addr1];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sum of the first n operands of the array, reduced modulo 2^res_w.
  function automatic longint model_sum(input bit init, input int n, input int res_w);
    longint s;
    longint x;
    s = 0;
    for (int j = 0; j < n; j++) begin
      x = longint'(mem[j]);
      if (x == 0) s += (init ? 2 : 3);
      else        s += (init ? x : 2 * x);
    end
    return s % (longint'(1) << res_w);
  endfunction

  task automatic load4(input int a, input int b, input int c, input int d);
    mem[0] = WIDTH'(a);
    mem[1] = WIDTH'(b);
    mem[2] = WIDTH'(c);
    mem[3] = WIDTH'(d);
  endtask

  // Start one run on the main DUT and check latency, pulse count, result and writes.
  task automatic run_check(input string tag, input bit init, input bit extra);
    longint exp;
    int first;
    int pulses;
    logic [ADDR_W-1:0] wa[$];
    logic [WIDTH-1:0]  wd[$];
    exp = model_sum(init, DEPTH, RES_W);
    @(negedge clk);
    r_enable0 = 1'b1;
    init_i    = init;
    @(negedge clk);
    r_enable0 = 1'b0;
    init_i    = ~init;
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (k == LAT - 1) check_val({tag, "_hold"}, 64'(result0), 64'(last_res));
      if (w_enable0) begin
        pulses++;
        if (first < 0) begin
          first = k;
          check_val({tag, "_result"}, 64'(result0), 64'(exp));
        end
      end
      if (wen0) begin
        wa.push_back(addr0);
        wd.push_back(wdata0);
      end
      if (extra && (k == 3)) r_enable0 = 1'b1;
      else                   r_enable0 = 1'b0;
    end
    check_val({tag, "_latency"}, 64'(first), 64'(LAT));
    check_val({tag, "_pulses"}, 64'(pulses), 64'd1);
    check_val({tag, "_held"}, 64'(result0), 64'(exp));
    if (WB) begin
      check_val({tag, "_nwrites"}, 64'(wa.size()), 64'(DEPTH));
      for (int j = 0; j < DEPTH && j < wa.size(); j++) begin
        check_val({tag, "_waddr"}, 64'(wa[j]), 64'(j));
        check_val({tag, "_wdata"}, 64'(wd[j]),
                  64'(model_sum(init, j + 1, RES_W) % (longint'(1) << WIDTH)));
      end
    end else begin
      check_val({tag, "_nwrites"}, 64'(wa.size()), 64'd0);
    end
    last_res = exp;
  endtask

  initial begin
    int first;
    int pulses;
    int writes;
    rst       = 1'b1;
    r_enable0 = 1'b1;
    r_enable1 = 1'b1;
    init_i    = 1'b1;
    load4(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("rst_result", 64'(result0), 64'd0);
    check_val("rst_wenable", 64'(w_enable0), 64'd0);
    check_val("rst_addr", 64'(addr0), 64'd0);
    check_val("rst_wstrobe", 64'(wen0), 64'd0);
    check_val("rst_wdata", 64'(wdata0), 64'd0);
    rst       = 1'b0;
    r_enable0 = 1'b0;
    r_enable1 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_wenable", 64'(w_enable0), 64'd0);

    // All-zero array, both modes; second run gets a spurious start mid-run.
    load4(0, 0, 0, 0);
    run_check("zero_init1", 1'b1, 1'b0);
    run_check("zero_init0_extra", 1'b0, 1'b1);

    // {1,2,3,4} back to back: 10 then 20, result holds 10 until second DONE.
    load4(1, 2, 3, 4);
    run_check("seq_init1", 1'b1, 1'b0);
    load4(1, 2, 3, 4);
    run_check("seq_init0", 1'b0, 1'b0);

    // Narrow result: 4 x 30 = 120 wraps to 8.
    load4(15, 15, 15, 15);
    @(negedge clk);
    r_enable1 = 1'b1;
    init_i    = 1'b0;
    @(negedge clk);
    r_enable1 = 1'b0;
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (w_enable1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check_val("wrap_latency", 64'(first), 64'(LAT));
    check_val("wrap_pulses", 64'(pulses), 64'd1);
    check_val("wrap_result", 64'(result1), 64'(model_sum(1'b0, DEPTH, RES_W_S)));
    check_val("wrap_const", 64'(result1), 64'd8);

    // Reset in the cycle after the second EXEC aborts the run.
    load4(1, 2, 3, 4);
    @(negedge clk);
    r_enable0 = 1'b1;
    init_i    = 1'b1;
    @(negedge clk);
    r_enable0 = 1'b0;
    repeat (WB ? 5 : 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_result", 64'(result0), 64'd0);
    check_val("abort_addr", 64'(addr0), 64'd0);
    pulses = 0;
    writes = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (w_enable0) pulses++;
      if (wen0) writes++;
    end
    check_val("abort_pulses", 64'(pulses), 64'd0);
    check_val("abort_writes", 64'(writes), 64'd0);
    check_val("abort_result_after", 64'(result0), 64'd0);
    last_res = 0;
    load4(1, 2, 3, 4);
    run_check("post_abort", 1'b1, 1'b0);

    // Random arrays and modes.
    for (int r = 0; r < 12; r++) begin
      bit init_r;
      for (int j = 0; j < DEPTH; j++) begin
        if ($urandom_range(0, 3) == 0) mem[j] = {WIDTH{1'b0}};
        else                           mem[j] = WIDTH'($urandom);
      end
      init_r = 1'($urandom);
      run_check($sformatf("rand%0d", r), init_r, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
